// File: rtl/forward_unit_pkg.sv
// Shared definitions for the operand-forwarding logic: register-address
// width and the EXE-stage forwarding mux select encodings, which the
// ALU-operand muxes decode with the same meaning.
package forward_unit_pkg;

  localparam int ASIZE = 5;

  typedef enum logic [1:0] {
    SEL_ID_EXE  = 2'b00,  // operand straight from the ID/EXE register
    SEL_MEM_WB  = 2'b01,  // operand from the MEM/WB writeback (memtoReg) mux
    SEL_EXE_MEM = 2'b10   // operand from the EXE/MEM ALU result
  } fwd_sel_e;

  // Number of forwarding events a registered select represents (0 or 1).
  function automatic logic [1:0] fwd_weight(input fwd_sel_e sel);
    return (sel != SEL_ID_EXE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/forward_unit_fwd_match.sv
// Match-and-priority for one source operand against the shadow EXE, MEM
// and WB destination tags. Produces the select the operand needs once its
// instruction reaches EXE, plus the raw EXE hit used for load-use detection.
module fwd_match
  import forward_unit_pkg::*;
#(
  parameter int AW = ASIZE
) (
  input  logic [AW-1:0] src,
  input  logic          exe_vld,
  input  logic          exe_rw,
  input  logic          exe_mr,
  input  logic [AW-1:0] exe_rd,
  input  logic          mem_vld,
  input  logic          mem_rw,
  input  logic [AW-1:0] mem_rd,
  input  logic          wb_vld,
  input  logic          wb_rw,
  input  logic [AW-1:0] wb_rd,
  output fwd_sel_e      sel,
  output logic          exe_hit
);

  logic mem_hit;
  logic wb_hit;

  // A stage produces src when it holds a real, register-writing instruction
  // targeting src; register 0 is hard-wired and never forwarded.
  function automatic logic producer(input logic vld, input logic rw,
                                    input logic [AW-1:0] rd,
                                    input logic [AW-1:0] s);
    return vld & rw & (rd == s) & (|s);
  endfunction

  assign exe_hit = producer(exe_vld, exe_rw, exe_rd, src);
  assign mem_hit = producer(mem_vld, mem_rw, mem_rd, src);
  assign wb_hit  = producer(wb_vld, wb_rw, wb_rd, src);

  // Youngest producer wins. A load still in EXE has no data yet; that case
  // is turned into a stall by the caller, so it falls through here.
  // A WB producer needs no bypass: the register file writes before it reads.
  always_comb begin
    sel = SEL_ID_EXE;
    if (exe_hit && !exe_mr) begin
      sel = SEL_EXE_MEM;
    end else if (mem_hit) begin
      sel = SEL_MEM_WB;
    end else if (wb_hit) begin
      sel = SEL_ID_EXE;
    end
  end

endmodule

// File: rtl/forward_unit.sv
// Operand-forwarding select generator and load-use stall detector for the
// 5-stage pipeline. Tracks destination tags of the instructions in EXE, MEM
// and WB in a shadow pipeline, decides selects while the consumer is in ID
// and registers them on the ID->EXE edge.
module forward_unit
  import forward_unit_pkg::*;
#(
  parameter int AW = ASIZE,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_ID,
  input  logic [AW-1:0] rs1_ID,
  input  logic [AW-1:0] rs2_ID,
  input  logic [AW-1:0] rd_ID,
  input  logic          regwrite_ID,
  input  logic          memread_ID,
  input  logic          flush,
  output logic [1:0]    selA,
  output logic [1:0]    selB,
  output logic          stall,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] fwd_cnt
);

  // Shadow EXE (p0), MEM (p1), WB (p2). Load status only matters while the
  // producer is in EXE, so it is not carried further.
  logic          vld_p0, rw_p0, mr_p0;
  logic [AW-1:0] rd_p0;
  logic          vld_p1, rw_p1;
  logic [AW-1:0] rd_p1;
  logic          vld_p2, rw_p2;
  logic [AW-1:0] rd_p2;

  fwd_sel_e      sel_a_nxt, sel_b_nxt;
  fwd_sel_e      sel_a_d, sel_b_d;
  fwd_sel_e      sel_a_p0, sel_b_p0;
  logic          exe_hit_a, exe_hit_b;
  logic          issue;
  logic [1:0]    fwd_inc;

  // Saturating add of a small increment.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt,
                                            input logic [1:0] inc);
    logic [CW:0] sum;
    sum = {1'b0, cnt} + {{(CW-1){1'b0}}, inc};
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

  fwd_match #(.AW(AW)) u_match_a (
    .src     (rs1_ID),
    .exe_vld (vld_p0),
    .exe_rw  (rw_p0),
    .exe_mr  (mr_p0),
    .exe_rd  (rd_p0),
    .mem_vld (vld_p1),
    .mem_rw  (rw_p1),
    .mem_rd  (rd_p1),
    .wb_vld  (vld_p2),
    .wb_rw   (rw_p2),
    .wb_rd   (rd_p2),
    .sel     (sel_a_nxt),
    .exe_hit (exe_hit_a)
  );

  fwd_match #(.AW(AW)) u_match_b (
    .src     (rs2_ID),
    .exe_vld (vld_p0),
    .exe_rw  (rw_p0),
    .exe_mr  (mr_p0),
    .exe_rd  (rd_p0),
    .mem_vld (vld_p1),
    .mem_rw  (rw_p1),
    .mem_rd  (rd_p1),
    .wb_vld  (vld_p2),
    .wb_rw   (rw_p2),
    .wb_rd   (rd_p2),
    .sel     (sel_b_nxt),
    .exe_hit (exe_hit_b)
  );

  // Load-use: the load in EXE cannot supply data to the ID consumer in time.
  // A taken branch kills the consumer, so flush suppresses the stall.
  assign stall = valid_ID & ~flush & mr_p0 & (exe_hit_a | exe_hit_b);

  // A stall or flush turns the ID->EXE transfer into a bubble.
  assign issue   = valid_ID & ~flush & ~stall;
  assign sel_a_d = issue ? sel_a_nxt : SEL_ID_EXE;
  assign sel_b_d = issue ? sel_b_nxt : SEL_ID_EXE;
  assign fwd_inc = fwd_weight(sel_a_d) + fwd_weight(sel_b_d);

  assign selA = sel_a_p0;
  assign selB = sel_b_p0;

  // ---- ID -> EXE: valid and selects ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      sel_a_p0 <= SEL_ID_EXE;
      sel_b_p0 <= SEL_ID_EXE;
    end else begin
      vld_p0   <= issue;
      sel_a_p0 <= sel_a_d;
      sel_b_p0 <= sel_b_d;
    end
  end

  // ---- ID -> EXE: destination tags, qualified by vld_p0 ----
  always_ff @(posedge clk) begin
    rd_p0 <= rd_ID;
    rw_p0 <= regwrite_ID;
    mr_p0 <= memread_ID;
  end

  // ---- EXE -> MEM -> WB: valids ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- EXE -> MEM -> WB: destination tags ----
  always_ff @(posedge clk) begin
    rd_p1 <= rd_p0;
    rw_p1 <= rw_p0;
    rd_p2 <= rd_p1;
    rw_p2 <= rw_p1;
  end

  // ---- event counters, advanced on the ID -> EXE edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      stall_cnt <= sat_add(stall_cnt, {1'b0, stall});
      fwd_cnt   <= sat_add(fwd_cnt, fwd_inc);
    end
  end

endmodule
